immediate_packer: RTL and testbench

IMMEDIATE_PACKER -- requirements
Module: immediate_packer

---
 rtl/immediate_packer.sv | 111 +++++++++++
 tb/tb_immediate_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_packer.sv
// RV32 instruction word packer: encodes one request per cycle into a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining IMMPACK_RANGECHECK_EN.
module immediate_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  SrcExt,
  input  logic [31:0] Imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b001,
    FMT_S   = 3'b010,
    FMT_B   = 3'b011,
    FMT_U   = 3'b100,
    FMT_J   = 3'b101,
    FMT_SHI = 3'b110
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] enc_instr;
  logic        enc_err;

`ifdef IMMPACK_RANGECHECK_EN
  // A value fits an N-bit signed field when all bits from N-1 upward are equal.
  logic range_bad;
  always_comb begin
    range_bad = 1'b0;
    case (SrcExt)
      FMT_I, FMT_S: range_bad = !((&Imm[31:11]) || (~|Imm[31:11]));
      FMT_B:        range_bad = !((&Imm[31:12]) || (~|Imm[31:12])) || Imm[0];
      FMT_U:        range_bad = |Imm[11:0];
      FMT_J:        range_bad = !((&Imm[31:20]) || (~|Imm[31:20])) || Imm[0];
      FMT_SHI:      range_bad = |Imm[31:5];
      default:      range_bad = 1'b0;
    endcase
  end
`endif

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (SrcExt)
      FMT_I:   enc_instr = {Imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   enc_instr = {Imm[11:5], rs2, rs1, funct3, Imm[4:0], opcode};
      FMT_B:   enc_instr = {Imm[12], Imm[10:5], rs2, rs1, funct3, Imm[4:1], Imm[11], opcode};
      FMT_U:   enc_instr = {Imm[31:12], rd, opcode};
      FMT_J:   enc_instr = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], rd, opcode};
      FMT_SHI: enc_instr = {funct7, Imm[4:0], rs1, funct3, rd, opcode};
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
`ifdef IMMPACK_RANGECHECK_EN
    if (range_bad) begin
      enc_instr = NOP;
      enc_err   = 1'b1;
    end
`endif
  end

  logic [32:0] mem [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // Gated by reset so the block refuses requests while held in reset.
  assign in_ready  = !reset && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_instr, out_err} = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {enc_instr, enc_err};
        wptr      <= ~wptr;
        if (enc_err && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      if (pop)
        rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_immediate_packer.sv
// Self-checking bench for immediate_packer: directed cases plus randomized traffic vs a queue model.
module tb_immediate_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  SrcExt;
  logic [31:0] Imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];
  int          m_err = 0;

`ifdef IMMPACK_RANGECHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  immediate_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcExt(SrcExt), .Imm(Imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference encoder built from the field layouts and numeric range limits.
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [31:0] imm,
      input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7);
    int          v;
    logic [31:0] w;
    bit          bad;
    v   = int'($signed(imm));
    bad = 1'b0;
    w   = 32'h13;
    case (f)
      3'd1: begin w = {imm[11:0], s1, f3, d, op};            bad = (v < -2048) || (v > 2047); end
      3'd2: begin w = {imm[11:5], s2, s1, f3, imm[4:0], op}; bad = (v < -2048) || (v > 2047); end
      3'd3: begin
        w   = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
        bad = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin w = {imm[31:12], d, op}; bad = (imm & 32'hFFF) != 0; end
      3'd5: begin
        w   = {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
        bad = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      3'd6: begin w = {f7, imm[4:0], s1, f3, d, op}; bad = imm > 32'd31; end
      default: return {32'h0000_0013, 1'b1};
    endcase
    if (RC && bad) return {32'h0000_0013, 1'b1};
    return {w, 1'b0};
  endfunction

  // Advance one clock from a negedge to the next, updating the model from the driven inputs.
  task automatic step();
    bit          push, pop;
    logic [32:0] e;
    e    = '0;
    pop  = (exp_q.size() > 0) && out_ready;
    push = in_valid && (exp_q.size() < 2);
    if (push) e = ref_encode(SrcExt, Imm, opcode, rd, rs1, rs2, funct3, funct7);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(e);
      if (e[0] && m_err < 255) m_err++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [31:0] imm, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7);
    SrcExt = f; Imm = imm; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk); @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (err_count !== 8'd0) $display("FAIL rst_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if ({out_instr, out_err} !== 33'd0) $display("FAIL rst_out_word: got %h/%b want 0/0", out_instr, out_err); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] want [3];
    want[0] = 32'hFFF10093; want[1] = 32'hFE209CE3; want[2] = 32'h001000EF;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_req(3'b001, -32'sd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0);
        1: set_req(3'b011, -32'sd8, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0);
        default: set_req(3'b101, 32'd2048, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
      endcase
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL dir%0d_latency: out_valid got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_instr !== want[k] || out_err !== 1'b0)
        $display("FAIL dir%0d_word: got %h/%b want %h/0", k, out_instr, out_err, want[k]); else n_pass++;
      n_checks++; if ({out_instr, out_err} !== exp_q[0])
        $display("FAIL dir%0d_model: got %h/%b want %h/%b", k, out_instr, out_err, exp_q[0][32:1], exp_q[0][0]); else n_pass++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_range();
    logic [7:0] base;
    base = err_count;
    set_req(3'b001, 32'd2048, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (RC) begin
      n_checks++; if (out_instr !== 32'h13 || out_err !== 1'b1)
        $display("FAIL range_i_2048: got %h/%b want 00000013/1", out_instr, out_err); else n_pass++;
      n_checks++; if (err_count !== base + 8'd1) $display("FAIL range_err_count: got %0d want %0d", err_count, base + 8'd1); else n_pass++;
    end else begin
      n_checks++; if (out_instr[31:20] !== 12'h800 || out_err !== 1'b0)
        $display("FAIL trunc_i_2048: got imm %h err %b want 800/0", out_instr[31:20], out_err); else n_pass++;
      n_checks++; if (err_count !== base) $display("FAIL trunc_err_count: got %0d want %0d", err_count, base); else n_pass++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(3'b010, 32'(idx * 5), 7'b0100011, 5'd0, 5'(idx + 1), 5'(idx + 7), 3'd2, 7'd0);
      in_valid = 1'b1;
      if (exp_q.size() < 2) idx++;
      step();
    end
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (exp_q.size() != 2 || idx != 2) $display("FAIL bp_accepts: model holds %0d want 2", exp_q.size()); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0))
        $display("FAIL bp_flags%0d: ready/valid got %b%b", c, in_ready, out_valid); else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++; if ({out_instr, out_err} !== exp_q[0])
          $display("FAIL bp_order%0d: got %h want %h", c, out_instr, exp_q[0][32:1]); else n_pass++;
      end
      if (idx < 3 && exp_q.size() < 2) begin
        set_req(3'b010, 32'(idx * 5), 7'b0100011, 5'd0, 5'(idx + 1), 5'(idx + 7), 3'd2, 7'd0);
        idx++;
      end else if (idx >= 3) in_valid = 1'b0;
      step();
      if (idx >= 3) in_valid = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained: out_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] edges [10];
    logic [31:0] r;
    edges[0] = 32'd2047;  edges[1] = -32'sd2048;  edges[2] = 32'd4094;   edges[3] = -32'sd4096;
    edges[4] = 32'd4095;  edges[5] = 32'd1048574; edges[6] = -32'sd1048576; edges[7] = 32'd1048576;
    edges[8] = 32'd31;    edges[9] = 32'd32;
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2))
        $display("FAIL rnd_flags@%0d: valid %b ready %b model size %0d", c, out_valid, in_ready, exp_q.size()); else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++; if ({out_instr, out_err} !== exp_q[0])
          $display("FAIL rnd_word@%0d: got %h/%b want %h/%b", c, out_instr, out_err, exp_q[0][32:1], exp_q[0][0]); else n_pass++;
      end
      n_checks++; if (err_count !== 8'(m_err)) $display("FAIL rnd_err_count@%0d: got %0d want %0d", c, err_count, m_err); else n_pass++;
      case ($urandom_range(0, 3))
        0: r = $urandom;
        1: r = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: r = edges[$urandom_range(0, 9)];
        default: begin r = $urandom; r[11:0] = ($urandom_range(0, 1) == 0) ? 12'h000 : r[11:0]; end
      endcase
      set_req(3'($urandom_range(0, 7)), r, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_err_saturation();
    set_req(3'b111, $urandom, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 310; c++) step();
    in_valid = 1'b0;
    n_checks++; if (out_instr !== 32'h13 || out_err !== 1'b1)
      $display("FAIL sat_illegal_word: got %h/%b want 00000013/1", out_instr, out_err); else n_pass++;
    n_checks++; if (err_count !== 8'd255) $display("FAIL sat_err_count: got %0d want 255", err_count); else n_pass++;
    step(); step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_req(3'b100, 32'h12345000, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0);
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL mid_prefill: valid %b ready %b want 1 0", out_valid, in_ready); else n_pass++;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_err = 0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (err_count !== 8'd0) $display("FAIL mid_rst_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0 || {out_instr, out_err} !== 33'd0)
      $display("FAIL mid_rst_outputs: ready %b word %h/%b want 0 0/0", in_ready, out_instr, out_err); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_release: ready %b valid %b want 1 0", in_ready, out_valid); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_range();
    test_back_to_back();
    test_random();
    test_err_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
